multiword_add_sequencer: RTL and testbench
==========================================

// Module: multiword_add_sequencer
// PURPOSE
//  Adds two WORDS*WIDTH-bit operands presented as WORDS beats of WIDTH bits, least significant beat first.
//  Sits downstream of operand staging and wraps one koggie_stone_adder (chunk width WIDTH).
//  Registers each beat's chunk sum and feeds the adder's c_out back as c_in for the next beat.
//  Uses valid/ready handshakes on both sides. Produces one result beat per accepted input beat.
// PARAMETERS
//  WIDTH   8   chunk width in bits; the adder instance width
//  WORDS   4   beats per operation; must be >= 1
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat
//  in_a       in   WIDTH  operand A chunk
//  in_b       in   WIDTH  operand B chunk
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts the result beat
//  out_sum    out  WIDTH  sum chunk
//  out_last   out  1      high on the final beat (beat WORDS-1) of an operation
//  out_carry  out  1      carry out of the full operation; valid only when out_last=1, otherwise 0
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
//  - Reset values: out_valid=0, out_sum=0, out_last=0, out_carry=0.
//    Internal state: beat counter cnt=0, carry register cy=0, FSM in IDLE.
//  - Accept condition: a beat is accepted when in_valid && in_ready.
//  - Ready rule: in_ready = !out_valid || out_ready. This is a single output stage with full throughput.
//  - Latency: a beat accepted in cycle N appears on out_* in cycle N+1.
//  - Adder carry input: c_in = (cnt==0) ? 0 : cy.
//  - On each accepted beat:
//    - out_sum <= chunk sum.
//    - out_valid <= 1.
//    - out_last <= (cnt==WORDS-1).
//  - Non-final accepted beat (cnt<WORDS-1): cy <= c_out, cnt <= cnt+1, out_carry <= 0.
//  - Final accepted beat (cnt==WORDS-1): out_carry <= c_out, cy <= 0, cnt <= 0.
//  - Output drain: out_valid drops to 0 when the output is accepted (out_valid && out_ready) and no new beat is accepted that cycle.
//  - Backpressure: while out_valid && !out_ready, out_sum, out_last and out_carry hold stable, in_ready=0, and cy/cnt do not change.
//  - FSM states:
//    - IDLE: cnt==0. An accepted beat goes to BUSY, or stays in IDLE when WORDS==1.
//    - BUSY: mid-operation. An accepted final beat returns to IDLE.
//  - WORDS==1: every beat is both first and last. c_in is always 0 (or 1 when subtracting, see CONFIGURATION). out_last=1 on every beat.
//  - Wrap-around: the sum is modulo 2^(WIDTH*WORDS). The overflow bit is reported only through out_carry.
//  - Reset mid-operation: the partial operation is discarded, cnt=0 and cy=0. The next accepted beat is treated as a first beat.
//  - Input gaps: in_valid may drop between beats. State holds indefinitely and there is no timeout.
// CONFIGURATION
//  MWADD_SUB_EN defined:
//   - Adds input port in_sub (1 bit). It is sampled only on the first beat (cnt==0) and held in sub_r for the rest of the operation.
//   - When subtracting, the adder's B input = ~in_b, and the first beat uses c_in = 1. Result = A - B.
//   - out_carry=1 on the final beat means no borrow.
//   - sub_r resets to 0.
//  MWADD_SUB_EN undefined: no in_sub port; the block only adds. Behaviour is exactly as described in BEHAVIOUR.
// STRUCTURE
//  - Package mwadd_pkg holds:
//    - localparams ST_IDLE=1'b0 and ST_BUSY=1'b1;
//    - function cnt_w(words) returning max(1, $clog2(words)), used to size cnt.
//  - One sub-module: koggie_stone_adder #(.WIDTH(WIDTH)), instance u_add. It is purely combinational.
//  - Everything else lives in this module: FSM, cnt, cy, output register.
// TESTING (WIDTH=8, WORDS=4 unless stated)
//  1. Add with carry chain:
//     - A=0x00FF_FFFF, B=0x0000_0001, beats sent back-to-back with out_ready=1.
//     - Required: out_sum = 00,00,00,01 (LS beat first); out_last only on the 4th beat; out_carry=0.
//  2. Full overflow:
//     - A=0xFFFF_FFFF, B=0x0000_0001.
//     - Required: all sum beats 0x00; out_carry=1 on the last beat; the next operation starts with c_in=0.
//  3. Backpressure:
//     - Hold out_ready=0 for 3 cycles after beat 1.
//     - Required: out_sum stable, in_ready=0, no beat lost.
//     - Required: two back-to-back operations stream at 1 beat per cycle once out_ready=1.
//  4. Reset mid-operation:
//     - Assert rst after 2 beats of A=0xFFFF_FFFF, B=0x0000_0001; release; send A=0x0000_0001, B=0x0000_0001.
//     - Required: out_sum = 02,00,00,00; no stale carry.
//  5. Single-word configuration, WORDS=1:
//     - A=0xF0, B=0x20 -> out_sum=0x10, out_last=1, out_carry=1.
//     - Next beat A=0x01, B=0x01 -> out_sum=0x02.
//  6. Subtract, MWADD_SUB_EN defined, in_sub=1:
//     - A=0x0000_0100, B=0x0000_0001 -> out_sum = FF,00,00,00, out_carry=1.
//     - Swapping the operands -> out_sum = 01,FF,FF,FF, out_carry=0.

Source files
------------

// File: rtl/mwadd_pkg.sv
// Shared definitions for the multi-word add sequencer: FSM state codes and
// the beat-counter width helper.
package mwadd_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // Beat counter width: max(1, clog2(words)).
    function automatic int unsigned cnt_w(input int unsigned words);
        int unsigned w;
        w = $clog2(words);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/koggie_stone_adder.sv
// Purely combinational Kogge-Stone parallel-prefix adder.
// Ports:
//   a, b   : WIDTH-bit addends
//   c_in   : carry input
//   sum    : WIDTH-bit sum
//   c_out  : carry out of the top bit
module koggie_stone_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int unsigned LV = $clog2(WIDTH);

    logic [WIDTH-1:0] hp;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   carry;

    // Prefix tree: after level l, g[i] is the group generate of bits [i:0]
    // (c_in folded into bit 0). Low bits of p are never consumed again, so
    // the shifted-in zeros there are harmless.
    always_comb begin
        hp = a ^ b;
        g  = a & b;
        p  = hp;
        g[0] = g[0] | (hp[0] & c_in);
        for (int unsigned l = 0; l < LV; l++) begin
            g = g | (p & (g << (32'd1 << l)));
            p = p & (p << (32'd1 << l));
        end
        carry = {g, c_in};
        sum   = hp ^ carry[WIDTH-1:0];
        c_out = carry[WIDTH];
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Adds two WORDS*WIDTH-bit operands streamed as WORDS beats of WIDTH bits,
// least significant beat first, with the chunk carry fed back between beats.
// Optional feature macro: MWADD_SUB_EN (adds in_sub; subtract A - B).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input beat handshake
//   in_a, in_b          : operand chunks
//   in_sub              : subtract select, sampled on first beat (MWADD_SUB_EN only)
//   out_valid/out_ready : result beat handshake
//   out_sum             : sum chunk
//   out_last            : final beat of an operation
//   out_carry           : carry of the whole operation (final beat only)
module multiword_add_sequencer
    import mwadd_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef MWADD_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_carry
);

    localparam int unsigned     CW       = cnt_w(WORDS);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WORDS - 1);

    logic             state_q;
    logic             state_d;
    logic [CW-1:0]    cnt_q;
    logic             cy_q;
    logic             accept;
    logic             first_beat;
    logic             last_beat;
    logic             c_in;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef MWADD_SUB_EN
    logic             sub_q;
    logic             sub_eff;
`endif

    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == CNT_LAST);

    koggie_stone_adder #(.WIDTH(WIDTH)) u_add (
        .a     (in_a),
        .b     (b_op),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: any accepted final beat closes the operation.
    always_comb begin
        state_d = state_q;
        if (accept) state_d = last_beat ? ST_IDLE : ST_BUSY;
    end

    // Handshake and adder operand selection.
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
`ifdef MWADD_SUB_EN
        sub_eff  = first_beat ? in_sub : sub_q;
        b_op     = sub_eff ? ~in_b : in_b;
        c_in     = first_beat ? sub_eff : cy_q;
`else
        b_op     = in_b;
        c_in     = first_beat ? 1'b0 : cy_q;
`endif
    end

    // Beat counter, inter-beat carry and output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            cy_q      <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_carry <= 1'b0;
        end else if (accept) begin
            out_sum   <= sum;
            out_valid <= 1'b1;
            out_last  <= last_beat;
            if (last_beat) begin
                out_carry <= c_out;
                cy_q      <= 1'b0;
                cnt_q     <= '0;
            end else begin
                out_carry <= 1'b0;
                cy_q      <= c_out;
                cnt_q     <= cnt_q + CW'(1);
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MWADD_SUB_EN
    // Operation mode is captured on the first beat and held to the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      sub_q <= 1'b0;
        else if (accept && first_beat) sub_q <= in_sub;
    end
`endif

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_last, out_carry;
    logic [7:0] in_a, in_b, out_sum;
    logic       in_sub;
    logic       v1, rdy1, ov1, or1, last1, carry1;
    logic [7:0] a1, b1, sum1;

    multiword_add_sequencer #(.WIDTH(8), .WORDS(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef MWADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_carry (out_carry)
    );

    multiword_add_sequencer #(.WIDTH(8), .WORDS(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .in_ready  (rdy1),
        .in_a      (a1),
        .in_b      (b1),
`ifdef MWADD_SUB_EN
        .in_sub    (1'b0),
`endif
        .out_valid (ov1),
        .out_ready (or1),
        .out_sum   (sum1),
        .out_last  (last1),
        .out_carry (carry1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int steps  = 0;
    logic rand_mode;

    // Reference model state for the WORDS=4 instance.
    logic              m_valid, m_last, m_carry, m_sub, step_acc;
    logic [7:0]        m_sum;
    int                mk;
    longint unsigned   acc_a, acc_b;

    typedef struct {
        logic [7:0] sum;
        logic       last;
        logic       carry;
    } beat_t;
    beat_t log_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_sum = 8'h00; m_last = 1'b0; m_carry = 1'b0;
        mk = 0; acc_a = 0; acc_b = 0; m_sub = 1'b0;
    endtask

    // One clock: compare against the model just before the edge, advance the
    // model by the handshake the edge will perform, return #1 after the edge.
    task automatic step();
        longint unsigned bb, tot, mask;
        int nb;
        beat_t bt;
        @(negedge clk);
        step_acc = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
            if (m_valid) begin
                chk("out_sum", 64'(out_sum), 64'(m_sum));
                chk("out_last", 64'(out_last), 64'(m_last));
                chk("out_carry", 64'(out_carry), 64'(m_carry));
            end
            if (out_valid && out_ready) begin
                bt.sum = out_sum; bt.last = out_last; bt.carry = out_carry;
                log_q.push_back(bt);
            end
            step_acc = in_valid && (!m_valid || out_ready);
            if (step_acc) begin
                if (mk == 0) begin
                    acc_a = 0;
                    acc_b = 0;
                    m_sub = in_sub;
`ifndef MWADD_SUB_EN
                    m_sub = 1'b0;
`endif
                end
                acc_a   = acc_a | (64'(in_a) << (8 * mk));
                acc_b   = acc_b | (64'(in_b) << (8 * mk));
                nb      = 8 * (mk + 1);
                mask    = (64'd1 << nb) - 64'd1;
                bb      = m_sub ? (~acc_b & mask) : acc_b;
                tot     = acc_a + bb + (m_sub ? 64'd1 : 64'd0);
                m_sum   = 8'(tot >> (8 * mk));
                m_last  = (mk == N - 1);
                m_carry = m_last ? 1'((tot >> nb) & 64'd1) : 1'b0;
                m_valid = 1'b1;
                mk      = m_last ? 0 : mk + 1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        steps++;
    endtask

    task automatic feed_beats(input logic [31:0] a, input logic [31:0] b, input logic sub,
                              input int first, input int n);
        logic done;
        for (int k = first; k < first + n; k++) begin
            in_valid = 1'b1;
            in_a     = 8'(a >> (8 * k));
            in_b     = 8'(b >> (8 * k));
            in_sub   = (k == 0) ? sub : 1'($urandom_range(0, 1));
            done     = 1'b0;
            for (int t = 0; t < 200 && !done; t++) begin
                if (rand_mode) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    in_valid  = ($urandom_range(0, 4) != 0);
                end
                step();
                done = step_acc;
            end
            if (!done) chk("accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic feed(input logic [31:0] a, input logic [31:0] b, input logic sub);
        feed_beats(a, b, sub, 0, N);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rand_mode = 1'b0;
        repeat (2) step();
    endtask

    // Compare the next four consumed beats against an expected result word.
    task automatic chk_log(input string name, input logic [31:0] word, input logic carry);
        beat_t bt;
        chk({name, "_beats"}, 64'(log_q.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (log_q.size() > 0) begin
                bt = log_q.pop_front();
                chk({name, "_sum"}, 64'(bt.sum), 64'(8'(word >> (8 * i))));
                chk({name, "_last"}, 64'(bt.last), 64'(i == 3));
                chk({name, "_carry"}, 64'(bt.carry), 64'((i == 3) ? carry : 1'b0));
            end
        end
    endtask

    initial begin
        int s0;
        vecs[0] = '{a: 8'hF0, b: 8'h20, sum: 8'h10, carry: 1'b1};
        vecs[1] = '{a: 8'h01, b: 8'h01, sum: 8'h02, carry: 1'b0};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, carry: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, sum: 8'h00, carry: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, sum: 8'h00, carry: 1'b1};
        vecs[5] = '{a: 8'h7F, b: 8'h01, sum: 8'h80, carry: 1'b0};
        vecs[6] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, carry: 1'b1};

        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
        out_ready = 1'b0; v1 = 1'b0; a1 = '0; b1 = '0; or1 = 1'b0;
        rand_mode = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_carry", 64'(out_carry), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst1_out_valid", 64'(ov1), 64'd0);
        chk("rst1_out_sum", 64'(sum1), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Carry ripples across three beats.
        feed(32'h00FF_FFFF, 32'h0000_0001, 1'b0);
        drain();
        chk_log("t1", 32'h0100_0000, 1'b0);

        // Full overflow, then a fresh operation must start with no carry.
        feed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        drain();
        chk_log("t2", 32'h0000_0000, 1'b1);
        feed(32'h0000_0000, 32'h0000_0000, 1'b0);
        drain();
        chk_log("t2_next", 32'h0000_0000, 1'b0);

        // Backpressure after the first beat.
        in_valid = 1'b1; in_a = 8'h01; in_b = 8'h10; in_sub = 1'b0;
        step();
        chk("t3_first_acc", 64'(step_acc), 64'd1);
        out_ready = 1'b0; in_a = 8'h02; in_b = 8'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_bp_ready", 64'(in_ready), 64'd0);
            chk("t3_bp_valid", 64'(out_valid), 64'd1);
            chk("t3_bp_sum", 64'(out_sum), 64'h11);
        end
        out_ready = 1'b1;
        feed_beats(32'h0403_0201, 32'h1010_1010, 1'b0, 1, 3);
        drain();
        chk_log("t3", 32'h1413_1211, 1'b0);

        // Two operations back to back at one beat per cycle.
        s0 = steps;
        feed(32'h89AB_CDEF, 32'h7654_3211, 1'b0);
        feed(32'h1234_5678, 32'hFEDC_BA98, 1'b0);
        chk("t3_throughput", 64'(steps - s0), 64'd8);
        drain();
        chk_log("t3_op1", 32'h0000_0000, 1'b1);
        chk_log("t3_op2", 32'h1111_1110, 1'b1);

        // Reset mid-operation discards the pending carry.
        feed_beats(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_valid_after_rst", 64'(out_valid), 64'd0);
        step();
        log_q.delete();
        feed(32'h0000_0001, 32'h0000_0001, 1'b0);
        drain();
        chk_log("t4", 32'h0000_0002, 1'b0);

        // Single-word instance: every beat is first and last.
        or1 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            v1 = 1'b1; a1 = vecs[i].a; b1 = vecs[i].b;
            chk("w1_in_ready", 64'(rdy1), 64'd1);
            step();
            chk("w1_valid", 64'(ov1), 64'd1);
            chk("w1_sum", 64'(sum1), 64'(vecs[i].sum));
            chk("w1_last", 64'(last1), 64'd1);
            chk("w1_carry", 64'(carry1), 64'(vecs[i].carry));
        end
        v1 = 1'b0;
        step();
        chk("w1_drain", 64'(ov1), 64'd0);

`ifdef MWADD_SUB_EN
        // Subtraction: out_carry=1 means no borrow.
        feed(32'h0000_0100, 32'h0000_0001, 1'b1);
        drain();
        chk_log("t6", 32'h0000_00FF, 1'b1);
        feed(32'h0000_0001, 32'h0000_0100, 1'b1);
        drain();
        chk_log("t6_swap", 32'hFFFF_FF01, 1'b0);
`endif

        // Random operands with random gaps and backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_mode = 1'b1;
            feed(32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
